timer_scheduler: RTL

Multi-channel one-shot timer block that shares a single free-running prescaler among CHANNELS independent timers. Requesters arm a channel with a tick count. Expired channels are queued and delivered one at a time on a valid/ready event port, using round-robin arbitration. It replaces per-consumer clock dividers for LED blink, debounce and timeout sequencing.

---
 rtl/timer_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/timer_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer scheduler: channel state encoding and
// the channel-index width helper.
package timer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  // A single channel still needs a one-bit index.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..PRESCALE-1 counter that emits a single-cycle tick
// while the count sits at its terminal value.
module tick_prescaler #(
  parameter int PRESCALE = 12000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // With PRESCALE=1 the count never leaves zero, so tick stays high.
  assign tick = (count == LAST);

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel one-shot timers sharing one prescaler; expired channels are
// delivered one per cycle on a registered valid/ready port, round-robin.
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 12000,
  parameter int CNT_W    = 16,
  localparam int CH_W    = ch_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm_valid,
  output logic                arm_ready,
  input  logic [CH_W-1:0]     arm_ch,
  input  logic [CNT_W-1:0]    arm_ticks,
  input  logic [CHANNELS-1:0] cancel,
  output logic [CHANNELS-1:0] busy,
  output logic                evt_valid,
  output logic [CH_W-1:0]     evt_ch,
  input  logic                evt_ready,
  output logic                tick_out
);

  logic [1:0]          state     [CHANNELS];
  logic [CNT_W-1:0]    remaining [CHANNELS];
  logic                tick;
  logic                arm_fire;
  logic                evt_accept;
  logic                arb_en;
  logic                arb_found;
  logic [CH_W-1:0]     arb_idx;
  logic [CH_W-1:0]     rr_ptr;
  logic [CHANNELS-1:0] pend_mask;

  // First set bit of mask at or after ptr, wrapping; returns {found, index}.
  function automatic logic [CH_W:0] rr_pick(input logic [CHANNELS-1:0] mask,
                                            input logic [CH_W-1:0] ptr);
    logic found;
    logic [CH_W-1:0] idx;
    int j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      j = (int'(ptr) + k) % CHANNELS;
      if (!found && mask[j]) begin
        found = 1'b1;
        idx   = CH_W'(j);
      end
    end
    return {found, idx};
  endfunction

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign tick_out   = tick;
  assign arm_fire   = arm_valid && arm_ready;
  assign evt_accept = evt_valid && evt_ready;
  assign arb_en     = !evt_valid || evt_accept;

  // Out-of-range channel numbers never handshake.
  always_comb begin
    arm_ready = 1'b0;
    if (int'(arm_ch) < CHANNELS) begin
      arm_ready = (state[arm_ch] == ST_IDLE);
    end
  end

  always_comb begin
    busy      = '0;
    pend_mask = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i]      = (state[i] != ST_IDLE);
      pend_mask[i] = (state[i] == ST_PENDING) &&
                     !(evt_accept && (evt_ch == CH_W'(i)));
    end
  end

  always_comb begin
    {arb_found, arb_idx} = rr_pick(pend_mask, rr_ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state[i]     <= ST_IDLE;
        remaining[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (arm_fire && (arm_ch == CH_W'(i))) begin
              if (arm_ticks == '0) begin
                state[i] <= ST_PENDING;
              end else begin
                state[i]     <= ST_RUNNING;
                remaining[i] <= arm_ticks;
              end
            end
          end
          // Cancel takes priority over an expiry on the same edge.
          ST_RUNNING: begin
            if (cancel[i]) begin
              state[i] <= ST_IDLE;
            end else if (tick) begin
              if (remaining[i] == CNT_W'(1)) begin
                state[i] <= ST_PENDING;
              end else begin
                remaining[i] <= remaining[i] - 1'b1;
              end
            end
          end
          ST_PENDING: begin
            if (evt_accept && (evt_ch == CH_W'(i))) begin
              state[i] <= ST_IDLE;
            end
          end
          default: state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      rr_ptr    <= '0;
    end else if (arb_en) begin
      evt_valid <= arb_found;
      if (arb_found) begin
        evt_ch <= arb_idx;
        rr_ptr <= (int'(arb_idx) == CHANNELS - 1) ? '0 : arb_idx + 1'b1;
      end
    end
  end

endmodule
